node_dot_engine: RTL

//  Neuron evaluator downstream of the block memory's 16-wide node read port.

---
 rtl/node_dot_pkg.sv | 47 ++++
 rtl/node_adder_tree.sv | 28 ++
 rtl/node_dot_engine.sv | 133 +++++++++++++
 3 files changed

// File: rtl/node_dot_pkg.sv
// Shared types and helpers for the node dot-product engine.
//   state_t  : engine FSM states
//   q88_t    : signed Q8.8 element / result type
//   prod_t   : full-precision element product
//   sum_t    : per-chunk adder tree result
//   acc_t    : running accumulator
//   sat_q88  : scale accumulator back to Q8.8 and saturate
package node_dot_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned ACC_W  = 48;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = PROD_W + 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_N,
    LOAD_W,
    ACCUM,
    WRITE,
    DONE
  } state_t;

  typedef logic signed [DATA_W-1:0] q88_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam acc_t Q_MAX = 48'sh7FFF;
  localparam acc_t Q_MIN = -48'sh8000;

  // Arithmetic shift floors toward -inf before the clamp.
  function automatic q88_t sat_q88(input acc_t acc);
    acc_t sh;
    sh = acc >>> FRAC_W;
    if (sh > Q_MAX)
      return q88_t'(Q_MAX[DATA_W-1:0]);
    else if (sh < Q_MIN)
      return q88_t'(Q_MIN[DATA_W-1:0]);
    else
      return q88_t'(sh[DATA_W-1:0]);
  endfunction

endpackage

// File: rtl/node_adder_tree.sv
// Combinational 16-input signed adder tree.
//   prods : 16 packed signed 32-bit products, lane i at [i*32 +: 32]
//   sum   : signed 36-bit total
module node_adder_tree
  import node_dot_pkg::*;
(
  input  logic [LANES*PROD_W-1:0] prods,
  output logic [SUM_W-1:0]        sum
);

  sum_t lvl0 [16];
  sum_t lvl1 [8];
  sum_t lvl2 [4];
  sum_t lvl3 [2];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++)
      lvl0[i] = sum_t'(prod_t'(prods[i*PROD_W +: PROD_W]));
    for (int unsigned i = 0; i < 8; i++)
      lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
    for (int unsigned i = 0; i < 4; i++)
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    for (int unsigned i = 0; i < 2; i++)
      lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
    sum = lvl3[0] + lvl3[1];
  end

endmodule

// File: rtl/node_dot_engine.sv
// Neuron evaluator: fetches N 16-lane node/weight chunk pairs through the
// block-memory node port, accumulates the signed Q8.8 dot product, then
// saturates, optionally applies ReLU and writes one result word.
//   iclk, irst        : clock, asynchronous active-high reset
//   iStart            : start request (accepted only in IDLE)
//   iNodeBase/iWeightBase/iLen/iDestAddr/iRelu : job parameters, captured on accept
//   oNodeAddr, iNodes : node port address and combinational 16-lane return
//   oDataAddr, oData, oDataWrite : result write port
//   oBusy, oDone      : status
module node_dot_engine
  import node_dot_pkg::*;
(
  input  logic                    iclk,
  input  logic                    irst,
  input  logic                    iStart,
  input  logic [ADDR_W-1:0]       iNodeBase,
  input  logic [ADDR_W-1:0]       iWeightBase,
  input  logic [7:0]              iLen,
  input  logic [ADDR_W-1:0]       iDestAddr,
  input  logic                    iRelu,
  output logic [ADDR_W-1:0]       oNodeAddr,
  input  logic [LANES*DATA_W-1:0] iNodes,
  output logic [ADDR_W-1:0]       oDataAddr,
  output logic [DATA_W-1:0]       oData,
  output logic                    oDataWrite,
  output logic                    oBusy,
  output logic                    oDone
);

  state_t               state;
  logic [ADDR_W-1:0]    nptr, wptr, dest;
  logic [ADDR_W-1:0]    node_addr_q, data_addr_q;
  logic [DATA_W-1:0]    data_q;
  logic [7:0]           remaining;
  logic                 relu;
  q88_t                 nreg [LANES];
  prod_t                prod [LANES];
  q88_t                 lane [LANES];
  logic [LANES*PROD_W-1:0] prod_flat;
  logic [SUM_W-1:0]     chunk_sum;
  acc_t                 acc;
  q88_t                 sat;
  q88_t                 result;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      lane[i] = q88_t'(iNodes[i*DATA_W +: DATA_W]);
      prod_flat[i*PROD_W +: PROD_W] = prod[i];
    end
  end

  node_adder_tree u_tree (
    .prods (prod_flat),
    .sum   (chunk_sum)
  );

  always_comb begin
    sat    = sat_q88(acc);
    result = (relu && sat[DATA_W-1]) ? '0 : sat;
  end

  // Output ports are driven per state; the *_q registers give the
  // hold-last-value behaviour outside the driving state.
  always_comb begin
    case (state)
      LOAD_N:  oNodeAddr = nptr;
      LOAD_W:  oNodeAddr = wptr;
      default: oNodeAddr = node_addr_q;
    endcase
    oDataWrite = (state == WRITE);
    oDataAddr  = (state == WRITE) ? dest : data_addr_q;
    oData      = (state == WRITE) ? result : data_q;
    oBusy      = (state != IDLE);
    oDone      = (state == DONE);
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state       <= IDLE;
      nptr        <= '0;
      wptr        <= '0;
      dest        <= '0;
      remaining   <= '0;
      relu        <= 1'b0;
      acc         <= '0;
      node_addr_q <= '0;
      data_addr_q <= '0;
      data_q      <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        nreg[i] <= '0;
        prod[i] <= '0;
      end
    end else begin
      node_addr_q <= oNodeAddr;
      data_addr_q <= oDataAddr;
      data_q      <= oData;
      case (state)
        IDLE: begin
          if (iStart) begin
            nptr      <= iNodeBase;
            wptr      <= iWeightBase;
            remaining <= iLen;
            dest      <= iDestAddr;
            relu      <= iRelu;
            acc       <= '0;
            state     <= (iLen != 8'd0) ? LOAD_N : WRITE;
          end
        end
        LOAD_N: begin
          for (int unsigned i = 0; i < LANES; i++)
            nreg[i] <= lane[i];
          state <= LOAD_W;
        end
        LOAD_W: begin
          for (int unsigned i = 0; i < LANES; i++)
            prod[i] <= prod_t'(nreg[i]) * prod_t'(lane[i]);
          state <= ACCUM;
        end
        ACCUM: begin
          acc       <= acc + acc_t'(sum_t'(chunk_sum));
          nptr      <= nptr + ADDR_W'(LANES);
          wptr      <= wptr + ADDR_W'(LANES);
          remaining <= remaining - 8'd1;
          state     <= (remaining == 8'd1) ? WRITE : LOAD_N;
        end
        WRITE:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
